// File: rtl/mips_main_control_fsm.sv
// mips_main_control_fsm
//   Multi-cycle MIPS main control unit. Sequences the datapath through
//   fetch / decode / execute / memory / writeback and decodes the state
//   register into datapath controls (Moore, except for the mem_ready gating
//   of IRWrite/PCWrite in FETCH and the illegal_op / mem_timeout flags).
//
//   Optional feature: define MIPS_ADDI_EN to decode addi (opcode 001000)
//   through ADDIEX -> ADDIWB. Without it, 001000 is reported as illegal.
//
// Parameters
//   MAX_WAIT    consecutive mem_ready-low cycles tolerated in a memory state
//               (FETCH/MEMRD/MEMWR) before abort to FETCH; 0 = no timeout
//
// Ports
//   clk, reset      rising-edge clock, async active-high reset
//   opcode[5:0]     IR[31:26]
//   mem_ready       memory completes the current access this cycle
//   PCWrite..ALUSrcA, ALUSrcB[1:0], PCSource[1:0], ALUop[1:0]  datapath controls
//   state[3:0]      current state code (debug)
//   illegal_op      unsupported opcode seen in DECODE
//   mem_timeout     one-cycle pulse when a memory wait is aborted
module mips_main_control_fsm #(
  parameter int MAX_WAIT = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       MemtoReg,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic       RegDst,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] PCSource,
  output logic [1:0] ALUop,
  output logic [3:0] state,
  output logic       illegal_op,
  output logic       mem_timeout
);

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_MEMADR = 4'd3,
    S_MEMRD  = 4'd4,
    S_MEMWB  = 4'd5,
    S_MEMWR  = 4'd6,
    S_EXEC   = 4'd7,
    S_ALUWB  = 4'd8,
    S_BRANCH = 4'd9,
    S_JUMP   = 4'd10,
    S_ADDIEX = 4'd11,
    S_ADDIWB = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
`ifdef MIPS_ADDI_EN
  localparam logic [5:0] OP_ADDI  = 6'b001000;
`endif

  // Counter only has to reach MAX_WAIT-1.
  localparam int          WW     = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
  localparam bit          TMO_EN = (MAX_WAIT > 0);
  localparam logic [WW-1:0] LIMIT = WW'((MAX_WAIT > 0) ? (MAX_WAIT - 1) : 0);

  state_t        cur, nxt, dec_nxt;
  logic [WW-1:0] wait_cnt;
  logic          mem_st, tmo, legal;

  // Opcode decode for the DECODE state.
  always_comb begin
    dec_nxt = S_FETCH;
    legal   = 1'b1;
    case (opcode)
      OP_RTYPE:     dec_nxt = S_EXEC;
      OP_LW, OP_SW: dec_nxt = S_MEMADR;
      OP_BEQ:       dec_nxt = S_BRANCH;
      OP_J:         dec_nxt = S_JUMP;
`ifdef MIPS_ADDI_EN
      OP_ADDI:      dec_nxt = S_ADDIEX;
`endif
      default:      legal   = 1'b0;
    endcase
  end

  // Next state. A timeout in any memory state lands in FETCH, which for
  // FETCH itself means a restart of the fetch.
  always_comb begin
    mem_st = (cur == S_FETCH) || (cur == S_MEMRD) || (cur == S_MEMWR);
    tmo    = TMO_EN && mem_st && !mem_ready && (wait_cnt == LIMIT);
    nxt    = S_FETCH;
    case (cur)
      S_IDLE:   nxt = S_FETCH;
      S_FETCH:  nxt = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: nxt = dec_nxt;
      S_MEMADR: nxt = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  nxt = mem_ready ? S_MEMWB : (tmo ? S_FETCH : S_MEMRD);
      S_MEMWB:  nxt = S_FETCH;
      S_MEMWR:  nxt = mem_ready ? S_FETCH : (tmo ? S_FETCH : S_MEMWR);
      S_EXEC:   nxt = S_ALUWB;
      S_ALUWB:  nxt = S_FETCH;
      S_BRANCH: nxt = S_FETCH;
      S_JUMP:   nxt = S_FETCH;
`ifdef MIPS_ADDI_EN
      S_ADDIEX: nxt = S_ADDIWB;
      S_ADDIWB: nxt = S_FETCH;
`endif
      default:  nxt = S_FETCH;
    endcase
  end

  // State and wait counter. The counter restarts on any completed access,
  // on a timeout (including the FETCH self-loop) and on every state change.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur      <= S_IDLE;
      wait_cnt <= '0;
    end else begin
      cur <= nxt;
      if (tmo || mem_ready || !mem_st || (nxt != cur))
        wait_cnt <= '0;
      else
        wait_cnt <= wait_cnt + WW'(1);
    end
  end

  // Control decode; anything not set in a state stays 0.
  always_comb begin
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    MemtoReg    = 1'b0;
    IRWrite     = 1'b0;
    RegWrite    = 1'b0;
    RegDst      = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = 2'b00;
    PCSource    = 2'b00;
    ALUop       = 2'b00;
    illegal_op  = 1'b0;
    case (cur)
      S_FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        // PC+4 and IR load only when the instruction word actually arrives.
        IRWrite = mem_ready;
        PCWrite = mem_ready;
      end
      S_DECODE: begin
        ALUSrcB    = 2'b11;
        illegal_op = !legal;
      end
      S_MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      S_MEMRD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
      end
      S_MEMWB: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
      end
      S_MEMWR: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
      end
      S_EXEC: begin
        ALUSrcA = 1'b1;
        ALUop   = 2'b10;
      end
      S_ALUWB: begin
        RegWrite = 1'b1;
        RegDst   = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA     = 1'b1;
        ALUop       = 2'b01;
        PCWriteCond = 1'b1;
        PCSource    = 2'b01;
      end
      S_JUMP: begin
        PCWrite  = 1'b1;
        PCSource = 2'b10;
      end
`ifdef MIPS_ADDI_EN
      S_ADDIEX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      S_ADDIWB: begin
        RegWrite = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  assign mem_timeout = tmo;
  assign state       = cur;

endmodule

// File: doc/mips_main_control_fsm.md
Name: mips_main_control_fsm

Overview:
- Multi-cycle MIPS main control unit. It decodes the instruction opcode and sequences the datapath through fetch/decode/execute/memory/writeback states.
- Produces the 2-bit ALUop consumed by the ALU control decoder: 00 add (lw/sw/PC), 01 subtract (beq), 10 use funct (R-type).
- Handshakes with instruction/data memory via mem_ready and enforces a bounded wait.

Parameters:
MAX_WAIT, 16, max consecutive mem_ready-low cycles tolerated in a memory state before abort; 0 disables timeout

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
opcode  input  6  instruction[31:26] from IR, sampled in DECODE
mem_ready  input  1  memory completes the current access this cycle
PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite, RegWrite, RegDst, ALUSrcA  output  1 each  datapath controls
ALUSrcB  output  2  00 regB, 01 const 4, 10 sign-ext imm, 11 imm<<2
PCSource  output  2  00 ALU result, 01 ALUOut, 10 jump target
ALUop  output  2  to ALU control decoder
state  output  4  current state code (debug)
illegal_op  output  1  high in DECODE when opcode is unsupported
mem_timeout  output  1  one-cycle pulse on wait abort

Behaviour:
- One clock; reset is asynchronous and active-high. Reset forces state=IDLE(0) and wait_cnt=0, so every output is 0 during and right after reset. IDLE always goes to FETCH on the next clock.
- Moore decode of the state register. Exceptions: IRWrite/PCWrite in FETCH are gated by mem_ready; illegal_op and mem_timeout depend on inputs. Outputs not listed for a state are 0.
- State codes: IDLE 0, FETCH 1, DECODE 2, MEMADR 3, MEMRD 4, MEMWB 5, MEMWR 6, EXEC 7, ALUWB 8, BRANCH 9, JUMP 10, ADDIEX 11, ADDIWB 12. Codes 13-15 go to FETCH.
- FETCH: MemRead=1, ALUSrcB=01, ALUop=00, IRWrite=PCWrite=mem_ready. Goes to DECODE when mem_ready=1, else holds.
- DECODE: ALUSrcB=11, ALUop=00. Next state by opcode:
  - 000000 -> EXEC
  - 100011 / 101011 -> MEMADR
  - 000100 -> BRANCH
  - 000010 -> JUMP
  - 001000 -> ADDIEX (feature only)
  - otherwise illegal_op=1 and next state FETCH
- MEMADR: ALUSrcA=1, ALUSrcB=10, ALUop=00. Goes to MEMRD if opcode=100011, else MEMWR.
- MEMRD: MemRead=1, IorD=1. Goes to MEMWB on mem_ready.
- MEMWB: RegWrite=1, MemtoReg=1, RegDst=0. Goes to FETCH.
- MEMWR: MemWrite=1, IorD=1. Goes to FETCH on mem_ready.
- EXEC: ALUSrcA=1, ALUSrcB=00, ALUop=10. Goes to ALUWB.
- ALUWB: RegWrite=1, RegDst=1. Goes to FETCH.
- BRANCH: ALUSrcA=1, ALUop=01, PCWriteCond=1, PCSource=01. Goes to FETCH.
- JUMP: PCWrite=1, PCSource=10. Goes to FETCH.
- Cycle counts with zero memory wait: lw 5, sw 4, R-type 4, beq 3, j 3.
- Wait counter (memory states FETCH/MEMRD/MEMWR only):
  - Increments each cycle mem_ready=0 in a memory state.
  - Clears on mem_ready=1 or on any state change.
  - If MAX_WAIT>0, wait_cnt==MAX_WAIT-1 and mem_ready=0: mem_timeout=1 that cycle, MemRead/MemWrite still asserted that cycle, next state FETCH, counter clears.
  - A timeout in FETCH restarts FETCH.
  - mem_ready=1 on the limit cycle wins: normal advance, no timeout.
- Reset asserted mid-instruction returns to IDLE immediately, with no partial register or memory write after reset release.

Optional Feature:
- MIPS_ADDI_EN defined: opcode 001000 decodes to ADDIEX, then ADDIWB, then FETCH.
  - ADDIEX: ALUSrcA=1, ALUSrcB=10, ALUop=00.
  - ADDIWB: RegWrite=1, RegDst=0, MemtoReg=0.
- MIPS_ADDI_EN undefined: 001000 is illegal (illegal_op=1, next state FETCH). States 11/12 are unreachable and go to FETCH.

Test Plan:
- Reset asserted async mid-cycle during EXEC -> all outputs 0, state=0 immediately; after release, state sequence 0,1,2.
- mem_ready=1 always, opcode=100011 -> states 1,2,3,4,5,1. MEMWB shows RegWrite=1, MemtoReg=1. ALUop sequence 00,00,00.
- opcode=000000 -> states 1,2,7,8,1. EXEC shows ALUop=10, ALUSrcA=1. ALUWB shows RegDst=1, RegWrite=1.
- opcode=000100, then 000010 -> BRANCH shows ALUop=01, PCWriteCond=1, PCSource=01. JUMP shows PCWrite=1, PCSource=10.
- MAX_WAIT=4, sw, mem_ready held 0 in MEMWR -> mem_timeout pulses on the 4th MEMWR cycle, next state FETCH. Repeat with mem_ready=1 on the 4th cycle -> no timeout, FETCH.
- opcode=001000 -> with MIPS_ADDI_EN, states 2,11,12,1. Without it, illegal_op=1 in DECODE and next state FETCH.
